// File: rtl/rx_frame_sync.sv
// 802.15.4 receive framer: hunts preamble/SFD, decodes PHR length and
// forwards only PSDU bits to the output FIFO write port.
module rx_frame_sync #(
    parameter int         PREAMBLE_MIN = 16,
    parameter logic [7:0] SFD          = 8'hA7,
    parameter int         MAX_LEN      = 127
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       i_data,
    input  logic       i_flag,
    input  logic       i_fifo_full,
    output logic       o_data,
    output logic       o_wr_en,
    output logic       o_frame_active,
    output logic       o_frame_done,
    output logic [6:0] o_frame_len,
    output logic       o_len_err,
    output logic       o_overflow
);

    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_PRE_OK  = 3'd1;
    localparam logic [2:0] S_SFD     = 3'd2;
    localparam logic [2:0] S_PHR     = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);
    localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

    logic [2:0] r_state;
    logic [5:0] r_zc;
    logic [2:0] r_bc;
    logic [9:0] r_pc;
    logic [7:0] r_sh;
    logic       r_data;
    logic       r_wr_en;
    logic       r_frame_active;
    logic       r_frame_done;
    logic [6:0] r_frame_len;
    logic       r_len_err;
    logic       r_overflow;

    logic [7:0] w_sh_nxt;
    logic [6:0] w_len;
    logic       w_len_ok;
    logic [5:0] w_zc_inc;
    logic [9:0] w_pc_last;

    assign w_sh_nxt  = {i_data, r_sh[7:1]};
    // PHR bit 7 is reserved, so only the low seven bits carry the length
    assign w_len     = w_sh_nxt[6:0];
    assign w_len_ok  = (w_len != 7'd0) && (w_len <= LEN_MAX);
    assign w_zc_inc  = r_zc + 6'd1;
    assign w_pc_last = {r_frame_len, 3'b000} - 10'd1;

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            r_state        <= S_HUNT;
            r_zc           <= '0;
            r_bc           <= '0;
            r_pc           <= '0;
            r_sh           <= '0;
            r_data         <= 1'b0;
            r_wr_en        <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_len    <= '0;
            r_len_err      <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_len_err    <= 1'b0;
            if (i_flag) begin
                r_sh <= w_sh_nxt;
                case (r_state)
                    S_HUNT: begin
                        if (i_data) begin
                            r_zc <= '0;
                        end else begin
                            r_zc <= w_zc_inc;
                            if (w_zc_inc == PRE_MIN) r_state <= S_PRE_OK;
                        end
                    end
                    S_PRE_OK: begin
                        if (i_data) begin
                            r_state <= S_SFD;
                            r_bc    <= 3'd1;
                        end
                    end
                    S_SFD: begin
                        r_bc <= r_bc + 3'd1;
                        if (r_bc == 3'd7) begin
                            if (w_sh_nxt == SFD) begin
                                r_state    <= S_PHR;
                                r_overflow <= 1'b0;
                            end else begin
                                // a trailing 0 already counts toward the next preamble
                                r_state <= S_HUNT;
                                r_zc    <= {5'd0, ~i_data};
                            end
                        end
                    end
                    S_PHR: begin
                        r_bc <= r_bc + 3'd1;
                        if (r_bc == 3'd7) begin
                            if (w_len_ok) begin
                                r_frame_len    <= w_len;
                                r_frame_active <= 1'b1;
                                r_pc           <= '0;
                                r_state        <= S_PAYLOAD;
                            end else begin
                                r_len_err <= 1'b1;
                                r_zc      <= '0;
                                r_state   <= S_HUNT;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        r_data  <= i_data;
                        r_wr_en <= ~i_fifo_full;
                        if (i_fifo_full) r_overflow <= 1'b1;
                        r_pc <= r_pc + 10'd1;
                        if (r_pc == w_pc_last) begin
                            r_frame_done   <= 1'b1;
                            r_frame_active <= 1'b0;
                            r_zc           <= '0;
                            r_state        <= S_HUNT;
                        end
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

    assign o_data         = r_data;
    assign o_wr_en        = r_wr_en;
    assign o_frame_active = r_frame_active;
    assign o_frame_done   = r_frame_done;
    assign o_frame_len    = r_frame_len;
    assign o_len_err      = r_len_err;
    assign o_overflow     = r_overflow;

endmodule
